// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_WORDS = 256;
  // First byte-address bit above the 256-word (1 KiB) memory window.
  localparam int unsigned MEM_SPAN_LSB = $clog2(MEM_WORDS) + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester A/B handshakes plus the data-memory port of mem_arbiter.
interface mem_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic              a_err;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic              b_err;
  logic [DATA_W-1:0] b_rdata;

  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_err, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_err, b_rdata,
    output MemRead, MemWrite, endereco, write_data,
    input  read_data
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_err, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_err, b_rdata,
    input  MemRead, MemWrite, endereco, write_data,
    output read_data
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; a tie goes to the port not granted last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic    req_a,
  input  logic    req_b,
  input  req_id_e last_grant,
  output req_id_e winner_c
);

  always_comb begin
    winner_c = REQ_A;
    if (req_a && req_b) begin
      winner_c = other_req(last_grant);
    end else if (req_b) begin
      winner_c = REQ_B;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates requesters A and B onto a 256-word data memory (IDLE/ACCESS/DONE).
// Optional feature macro: MEM_ARB_BOUNDS_CHECK_EN (rejects addresses above 1 KiB with err).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input logic          clock,
  input logic          reset_n,
  mem_arbiter_if.slave bus
);

`ifdef MEM_ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_e  state;
  req_id_e last_grant;
  req_id_e winner;
  logic    lat_we;
  logic    lat_oob;

  req_id_e           win_c;
  logic              any_req_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;
  logic              sel_oob_c;

  rr_arb2 u_rr_arb2 (
    .req_a      (bus.a_req),
    .req_b      (bus.b_req),
    .last_grant (last_grant),
    .winner_c   (win_c)
  );

  // Mux the winning requester's command for capture in IDLE.
  always_comb begin
    any_req_c   = bus.a_req | bus.b_req;
    sel_we_c    = (win_c == REQ_A) ? bus.a_we    : bus.b_we;
    sel_addr_c  = (win_c == REQ_A) ? bus.a_addr  : bus.b_addr;
    sel_wdata_c = (win_c == REQ_A) ? bus.a_wdata : bus.b_wdata;
    sel_oob_c   = BOUNDS_EN && (sel_addr_c[ADDR_W-1:MEM_SPAN_LSB] != '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      last_grant     <= REQ_B;
      winner         <= REQ_A;
      lat_we         <= 1'b0;
      lat_oob        <= 1'b0;
      bus.a_ack      <= 1'b0;
      bus.b_ack      <= 1'b0;
      bus.a_rdata    <= '0;
      bus.b_rdata    <= '0;
      bus.MemRead    <= 1'b0;
      bus.MemWrite   <= 1'b0;
      bus.endereco   <= '0;
      bus.write_data <= '0;
    end else begin
      // Memory strobes and acks are single-cycle; everything idles at zero.
      bus.a_ack      <= 1'b0;
      bus.b_ack      <= 1'b0;
      bus.MemRead    <= 1'b0;
      bus.MemWrite   <= 1'b0;
      bus.endereco   <= '0;
      bus.write_data <= '0;
      unique case (state)
        IDLE: begin
          if (any_req_c) begin
            winner         <= win_c;
            last_grant     <= win_c;
            lat_we         <= sel_we_c;
            lat_oob        <= sel_oob_c;
            bus.MemRead    <= !sel_we_c && !sel_oob_c;
            bus.MemWrite   <= sel_we_c && !sel_oob_c;
            bus.endereco   <= sel_addr_c;
            bus.write_data <= sel_wdata_c;
            state          <= ACCESS;
          end
        end
        ACCESS: begin
          if (winner == REQ_A) begin
            bus.a_ack <= 1'b1;
          end else begin
            bus.b_ack <= 1'b1;
          end
          if (!lat_we && !lat_oob) begin
            if (winner == REQ_A) begin
              bus.a_rdata <= bus.read_data;
            end else begin
              bus.b_rdata <= bus.read_data;
            end
          end
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_BOUNDS_CHECK_EN
  // err accompanies ack for a rejected out-of-window access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.a_err <= 1'b0;
      bus.b_err <= 1'b0;
    end else begin
      bus.a_err <= (state == ACCESS) && lat_oob && (winner == REQ_A);
      bus.b_err <= (state == ACCESS) && lat_oob && (winner == REQ_B);
    end
  end
`else
  assign bus.a_err = 1'b0;
  assign bus.b_err = 1'b0;
`endif

endmodule
